bus2_arbiter: RTL

Shares memory-controller bus 2 (command/address/control lines) between two line-transfer requesters, e.g. the L1 cache and a DMA/prefetch engine. Picks a winner round-robin and drives its command and address for one cycle. Holds ownership through the controller's delay and the data beats, then releases with a turnaround cycle. A watchdog aborts transactions the memory controller never answers.

---
 rtl/bus2_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bus2_arbiter.sv
// bus2_arbiter
//   Shares memory-controller bus 2 (C2 command, A2 address) between two
//   line-transfer requesters. Round-robin winner selection, one-cycle command
//   issue, ownership held through controller latency and data beats, one-cycle
//   turnaround release, and a watchdog that aborts unanswered transactions.
//
// Ports
//   CLK, RESET       clock, synchronous active-high reset
//   REQ[1:0]         per-requester request level
//   CMD0/CMD1        requested command (READ_LINE / WRITE_LINE)
//   ADDR0/ADDR1      requested line address
//   C2_IN            sampled C2 bus (memory controller side)
//   GNT[1:0]         one-hot ownership for the whole transaction
//   C2_OUT, C2_OE    command driven onto C2 and its enable (ISSUE only)
//   A2_OUT           address driven onto A2 (ISSUE only)
//   BEAT, BEAT_VLD   data beat index and beat-present flag
//   DONE[1:0]        one-cycle success pulse to the owner
//   ERR[1:0]         one-cycle timeout pulse to the owner
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | no owner; arbitrate among valid requests
// ISSUE      | drive latched command/address on C2/A2 for one cycle
// WBEATS     | owner drives write data, LINE_BEATS beats
// WAIT_RESP  | waiting for C2_RESPONSE, watchdog running
// RBEATS     | read data beats 1..LINE_BEATS-1 (beat 0 is the response cycle)
// RELEASE    | turnaround, no grant, DONE or ERR pulse to previous owner

module bus2_arbiter #(
  parameter int ADDR2_BUS_SIZE = 15,
  parameter int CTR2_BUS_SIZE  = 2,
  parameter int LINE_BEATS     = 8,
  parameter int TIMEOUT        = 255
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [1:0]                REQ,
  input  logic [CTR2_BUS_SIZE-1:0]  CMD0,
  input  logic [CTR2_BUS_SIZE-1:0]  CMD1,
  input  logic [ADDR2_BUS_SIZE-1:0] ADDR0,
  input  logic [ADDR2_BUS_SIZE-1:0] ADDR1,
  input  logic [CTR2_BUS_SIZE-1:0]  C2_IN,
  output logic [1:0]                GNT,
  output logic [CTR2_BUS_SIZE-1:0]  C2_OUT,
  output logic                      C2_OE,
  output logic [ADDR2_BUS_SIZE-1:0] A2_OUT,
  output logic [2:0]                BEAT,
  output logic                      BEAT_VLD,
  output logic [1:0]                DONE,
  output logic [1:0]                ERR
);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  localparam int          WD_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [2:0]  LAST_BEAT = 3'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WBEATS, S_WAIT_RESP, S_RBEATS, S_RELEASE
  } state_t;

  state_t                    state_q, state_d;
  logic                      last_q;
  logic [CTR2_BUS_SIZE-1:0]  cmd_q;
  logic [ADDR2_BUS_SIZE-1:0] addr_q;
  logic [2:0]                beat_q, beat_d;
  logic [WD_W-1:0]           wd_q;
  logic                      ok_q;

  logic valid0, valid1, any_valid, win, resp, is_read;
  logic [1:0] owner;

  assign valid0    = REQ[0] && (CMD0 == C2_READ_LINE || CMD0 == C2_WRITE_LINE);
  assign valid1    = REQ[1] && (CMD1 == C2_READ_LINE || CMD1 == C2_WRITE_LINE);
  assign any_valid = valid0 || valid1;
  // On a tie the requester that did not win last time goes next.
  assign win       = (valid0 && valid1) ? ~last_q : valid1;
  assign resp      = (C2_IN == C2_RESPONSE);
  assign is_read   = (cmd_q == C2_READ_LINE);
  assign owner     = last_q ? 2'b10 : 2'b01;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (any_valid) state_d = S_ISSUE;
      S_ISSUE:     state_d = is_read ? S_WAIT_RESP : S_WBEATS;
      S_WBEATS:    if (beat_q == LAST_BEAT) state_d = S_WAIT_RESP;
      S_WAIT_RESP: begin
        // A response in the same cycle the watchdog expires still wins.
        if (resp)              state_d = is_read ? S_RBEATS : S_RELEASE;
        else if (wd_q == '0)   state_d = S_RELEASE;
      end
      S_RBEATS:    if (beat_q == LAST_BEAT) state_d = S_RELEASE;
      S_RELEASE:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // The response cycle of a read is already beat 0, so RBEATS starts at 1.
  always_comb begin
    beat_d = '0;
    if (state_d == S_WBEATS || state_d == S_RBEATS) begin
      if (state_q == state_d)          beat_d = beat_q + 3'd1;
      else if (state_q == S_WAIT_RESP) beat_d = 3'd1;
      else                             beat_d = '0;
    end
  end

  // Transaction datapath: owner, latched command/address, beats, watchdog
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_q <= 1'b1;
      cmd_q  <= C2_NOP;
      addr_q <= '0;
      beat_q <= '0;
      wd_q   <= '0;
      ok_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && any_valid) begin
        last_q <= win;
        cmd_q  <= win ? CMD1 : CMD0;
        addr_q <= win ? ADDR1 : ADDR0;
      end
      beat_q <= beat_d;
      // Down-counter: reaches zero on the TIMEOUT-th cycle after entry.
      if (state_q != S_WAIT_RESP && state_d == S_WAIT_RESP)
        wd_q <= WD_W'(TIMEOUT);
      else if (state_q == S_WAIT_RESP && wd_q != '0)
        wd_q <= wd_q - WD_W'(1);
      if (state_q != S_RELEASE && state_d == S_RELEASE)
        ok_q <= !(state_q == S_WAIT_RESP && !resp);
    end
  end

  // Outputs
  always_comb begin
    GNT      = 2'b00;
    C2_OUT   = C2_NOP;
    C2_OE    = 1'b0;
    A2_OUT   = '0;
    BEAT     = beat_q;
    BEAT_VLD = 1'b0;
    DONE     = 2'b00;
    ERR      = 2'b00;
    case (state_q)
      S_ISSUE: begin
        GNT    = owner;
        C2_OUT = cmd_q;
        C2_OE  = 1'b1;
        A2_OUT = addr_q;
      end
      S_WBEATS, S_RBEATS: begin
        GNT      = owner;
        BEAT_VLD = 1'b1;
      end
      S_WAIT_RESP: begin
        GNT      = owner;
        BEAT_VLD = is_read && resp;
      end
      S_RELEASE: begin
        DONE = ok_q ? owner : 2'b00;
        ERR  = ok_q ? 2'b00 : owner;
      end
      default: ;
    endcase
  end

endmodule
